// File: rtl/fpu_wb_buffer_pkg.sv
// Shared definitions for the FPU writeback buffer: word/register widths,
// FPU opcodes, float field positions, entry state encoding.
// Optional build macro used by the top: FWB_BYPASS_EN.
package fpu_wb_buffer_pkg;

    localparam int WORD_W = 16;   // one machine word
    localparam int REG_W  = 4;    // register index width

    // Destination register that doubles as the PC; Stage 0 turns a write to it into a jump.
    localparam logic [REG_W-1:0] PCWRITE = 4'hF;

    // Float word layout: 1 sign, 8 exponent, 7 mantissa.
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 7;
    localparam int MANT_MSB = 6;
    localparam int MANT_LSB = 0;

    // Magnitude bits only; a word that is zero under this mask is +0 or -0.
    localparam logic [WORD_W-1:0] MAG_MASK = 16'h7FFF;

    typedef enum logic [3:0] {
        OP_ITOF = 4'h8,
        OP_FTOI = 4'h9,
        OP_MULF = 4'hA,
        OP_ADDF = 4'hB,
        OP_SUBF = 4'hC,
        OP_RECF = 4'hD
    } fpu_op_t;

    typedef enum logic [1:0] {
        ENT_FREE   = 2'd0,
        ENT_ALLOC  = 2'd1,
        ENT_FILLED = 2'd2
    } ent_state_t;

    function automatic logic f_is_zero(input logic [WORD_W-1:0] w);
        return (w & MAG_MASK) == '0;
    endfunction

endpackage

// File: rtl/fpu_wb_buffer_entry.sv
// One completion-buffer slot: state, destination, Z-request and result registers.
// Ports: clk/reset; flush; alloc (+dest, setz); fill (+value); free;
//        state/dest/setz/value expose the stored slot contents.
module fpu_wb_buffer_entry
    import fpu_wb_buffer_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc,
    input  logic [REG_W-1:0] alloc_dest,
    input  logic             alloc_setz,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_value,
    input  logic             free,
    output ent_state_t       state,
    output logic [REG_W-1:0] dest,
    output logic             setz,
    output logic [WIDTH-1:0] value
);

    ent_state_t state_nxt;

    // Later assignments win: alloc+fill in one cycle lands FILLED (zero-latency
    // fpu result), fill+free lands FREE (bypassed result consumed directly).
    always_comb begin
        state_nxt = state;
        if (alloc) state_nxt = ENT_ALLOC;
        if (fill)  state_nxt = ENT_FILLED;
        if (free)  state_nxt = ENT_FREE;
        if (flush) state_nxt = ENT_FREE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ENT_FREE;
            dest  <= '0;
            setz  <= 1'b0;
            value <= '0;
        end else begin
            state <= state_nxt;
            if (alloc && !flush) begin
                dest <= alloc_dest;
                setz <= alloc_setz;
            end
            if (fill && !flush) begin
                value <= fill_value;
            end
        end
    end

endmodule

// File: rtl/fpu_wb_buffer.sv
// In-order completion buffer between the multi-cycle fpu and Stage 0 writeback.
// Ports: issue_* allocate at tail (full blocks), fpu_done/fpu_result fill oldest
//        unfilled entry, wb_* valid/ready drain at head, busy = per-register
//        pending mask, count = allocated entries, err = sticky protocol error.
// Build option: define FWB_BYPASS_EN to present a result on wb_* in the same
// cycle fpu_done fills the head entry of a buffer holding no filled entry.
module fpu_wb_buffer
    import fpu_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [REG_W-1:0]       issue_dest,
    input  logic                   issue_setz,
    output logic                   full,
    input  logic                   fpu_done,
    input  logic [WIDTH-1:0]       fpu_result,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [REG_W-1:0]       wb_dest,
    output logic [WIDTH-1:0]       wb_value,
    output logic                   wb_setz,
    output logic                   wb_zero,
    output logic [15:0]            busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] tail;

    ent_state_t       ent_state [DEPTH];
    logic [REG_W-1:0] ent_dest  [DEPTH];
    logic             ent_setz  [DEPTH];
    logic [WIDTH-1:0] ent_value [DEPTH];

    logic issue_acc;
    logic fill_ok;
    logic fill_acc;
    logic head_filled;
    logic pop;

    // Decided on the registered count alone, so a pop in the same cycle
    // never opens a slot for an issue.
    assign full      = (count == CW'(DEPTH));
    assign issue_acc = issue_valid && !full;

    // fill_ptr always sits on the oldest ALLOC entry, or on tail when none
    // exists. An empty buffer may fill the entry being allocated right now.
    assign fill_ok  = (ent_state[fill_ptr] == ENT_ALLOC) || (issue_acc && (count == '0));
    assign fill_acc = fpu_done && fill_ok;

    // Filled entries are contiguous from head, so checking head is enough.
    assign head_filled = (ent_state[head] == ENT_FILLED);
    assign pop         = wb_valid && wb_ready;

    always_comb begin
        wb_valid = 1'b0;
        wb_dest  = '0;
        wb_value = '0;
        wb_setz  = 1'b0;
        if (head_filled) begin
            wb_valid = 1'b1;
            wb_dest  = ent_dest[head];
            wb_value = ent_value[head];
            wb_setz  = ent_setz[head];
        end
`ifdef FWB_BYPASS_EN
        else if (fill_acc && !flush) begin
            // The filling entry is the head. With count==0 it is being
            // allocated this same cycle, so its tag comes from the issue port.
            wb_valid = 1'b1;
            wb_value = fpu_result;
            if (count == '0) begin
                wb_dest = issue_dest;
                wb_setz = issue_setz;
            end else begin
                wb_dest = ent_dest[head];
                wb_setz = ent_setz[head];
            end
        end
`endif
    end

    assign wb_zero = wb_valid && f_is_zero(wb_value);

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_state[i] != ENT_FREE) begin
                busy[ent_dest[i]] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        fpu_wb_buffer_entry #(
            .WIDTH (WIDTH)
        ) u_ent (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .alloc      (issue_acc && (tail == PW'(g))),
            .alloc_dest (issue_dest),
            .alloc_setz (issue_setz),
            .fill       (fill_acc && (fill_ptr == PW'(g))),
            .fill_value (fpu_result),
            .free       (pop && (head == PW'(g))),
            .state      (ent_state[g]),
            .dest       (ent_dest[g]),
            .setz       (ent_setz[g]),
            .value      (ent_value[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (flush) begin
            // err is deliberately kept: it records protocol history.
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue_acc) tail     <= tail + PW'(1);
            if (fill_acc)  fill_ptr <= fill_ptr + PW'(1);
            if (pop)       head     <= head + PW'(1);
            case ({issue_acc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if ((issue_valid && full) || (fpu_done && !fill_ok)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Directed self-checking bench for fpu_wb_buffer (DEPTH=4, WIDTH=16).
module tb_fpu_wb_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [3:0]  issue_dest;
    logic        issue_setz;
    logic        full;
    logic        fpu_done;
    logic [15:0] fpu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dest;
    logic [15:0] wb_value;
    logic        wb_setz;
    logic        wb_zero;
    logic [15:0] busy;
    logic [2:0]  count;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_wb_buffer #(.DEPTH(4), .WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_setz  (issue_setz),
        .full        (full),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .wb_setz     (wb_setz),
        .wb_zero     (wb_zero),
        .busy        (busy),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = 4'd0;
        issue_setz  = 1'b0;
        fpu_done    = 1'b0;
        fpu_result  = 16'h0;
        wb_ready    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [15:0] vals [4];

    initial begin
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        vals[3] = 16'h4444;

        // Reset state
        do_reset();
        check("rst_full",     32'(full),     0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_wb_dest",  32'(wb_dest),  0);
        check("rst_wb_value", 32'(wb_value), 0);
        check("rst_wb_zero",  32'(wb_zero),  0);
        check("rst_busy",     32'(busy),     0);
        check("rst_count",    32'(count),    0);
        check("rst_err",      32'(err),      0);

        // Single op: issue r3, result two cycles later, drained in one cycle
        issue_valid = 1'b1; issue_dest = 4'd3; issue_setz = 1'b0;
        check("t1_busy_pre", 32'(busy), 0);
        step();
        issue_valid = 1'b0;
        check("t1_busy_issued", 32'(busy), 'h0008);
        check("t1_count", 32'(count), 1);
        step();
        fpu_done = 1'b1; fpu_result = 16'h4780;
        step();
        fpu_done = 1'b0; wb_ready = 1'b1;
        check("t1_wb_valid", 32'(wb_valid), 1);
        check("t1_wb_dest",  32'(wb_dest),  3);
        check("t1_wb_value", 32'(wb_value), 'h4780);
        check("t1_busy_filled", 32'(busy), 'h0008);
        step();
        check("t1_wb_valid_after", 32'(wb_valid), 0);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_count_after", 32'(count), 0);

        // Fill to capacity, overflow, in-order drain, pointer wrap
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1'b1; issue_dest = 4'(i);
            step();
        end
        issue_dest = 4'd5;
        check("t2_full",  32'(full),  1);
        check("t2_count", 32'(count), 4);
        check("t2_err_before", 32'(err), 0);
        step();
        issue_valid = 1'b0;
        check("t2_err_overflow", 32'(err), 1);
        check("t2_count_hold", 32'(count), 4);
        check("t2_busy", 32'(busy), 'h001E);
        for (int k = 0; k < 4; k++) begin
            fpu_done = 1'b1; fpu_result = vals[k];
            step();
        end
        fpu_done = 1'b0;
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_valid", 32'(wb_valid), 1);
            check("t2_drain_dest",  32'(wb_dest),  32'(k + 1));
            check("t2_drain_value", 32'(wb_value), 32'(vals[k]));
            step();
        end
        wb_ready = 1'b0;
        check("t2_empty_valid", 32'(wb_valid), 0);
        check("t2_empty_count", 32'(count), 0);
        issue_valid = 1'b1; issue_dest = 4'd7;
        step();
        issue_valid = 1'b0; fpu_done = 1'b1; fpu_result = 16'h5555;
        step();
        fpu_done = 1'b0;
        check("t2_wrap_valid", 32'(wb_valid), 1);
        check("t2_wrap_dest",  32'(wb_dest),  7);
        check("t2_wrap_value", 32'(wb_value), 'h5555);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("t2_wrap_count", 32'(count), 0);

        // Z flag request and float zero detection
        do_reset();
        issue_valid = 1'b1; issue_dest = 4'd2; issue_setz = 1'b1;
        step();
        issue_valid = 1'b0; fpu_done = 1'b1; fpu_result = 16'h8000;
        step();
        fpu_done = 1'b0;
        check("t3_setz",   32'(wb_setz),  1);
        check("t3_zero",   32'(wb_zero),  1);
        check("t3_value",  32'(wb_value), 'h8000);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        issue_valid = 1'b1; issue_dest = 4'd2; issue_setz = 1'b0;
        step();
        issue_valid = 1'b0; fpu_done = 1'b1; fpu_result = 16'h3F80;
        step();
        fpu_done = 1'b0;
        check("t3_nz_zero",  32'(wb_zero),  0);
        check("t3_nz_setz",  32'(wb_setz),  0);
        check("t3_nz_value", 32'(wb_value), 'h3F80);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // Flush with a concurrent fill, then a stale fpu_done
        do_reset();
        issue_valid = 1'b1; issue_dest = 4'd6;
        step();
        issue_dest = 4'd9;
        step();
        issue_valid = 1'b0; fpu_done = 1'b1; fpu_result = 16'h1111;
        step();
        fpu_done = 1'b0;
        check("t4_count_pre", 32'(count), 2);
        check("t4_busy_pre",  32'(busy), 'h0240);
        flush = 1'b1; fpu_done = 1'b1; fpu_result = 16'h2222;
        step();
        flush = 1'b0; fpu_done = 1'b0;
        check("t4_flush_count", 32'(count), 0);
        check("t4_flush_busy",  32'(busy), 0);
        check("t4_flush_valid", 32'(wb_valid), 0);
        check("t4_flush_err",   32'(err), 0);
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        check("t4_stale_err",   32'(err), 1);
        check("t4_stale_valid", 32'(wb_valid), 0);

        // fpu_done on empty buffer, then async reset mid-drain
        do_reset();
        fpu_done = 1'b1; fpu_result = 16'h7777;
        step();
        fpu_done = 1'b0;
        check("t5_err",   32'(err), 1);
        check("t5_valid", 32'(wb_valid), 0);
        check("t5_count", 32'(count), 0);
        issue_valid = 1'b1; issue_dest = 4'd10;
        step();
        issue_dest = 4'd11; fpu_done = 1'b1; fpu_result = 16'hAAAA;
        step();
        issue_valid = 1'b0; fpu_result = 16'hBBBB;
        step();
        fpu_done = 1'b0; wb_ready = 1'b1;
        check("t5_drain0_dest", 32'(wb_dest), 10);
        step();
        check("t5_drain1_valid", 32'(wb_valid), 1);
        check("t5_drain1_dest",  32'(wb_dest), 11);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(wb_valid), 0);
        check("t5_rst_dest",  32'(wb_dest), 0);
        check("t5_rst_value", 32'(wb_value), 0);
        check("t5_rst_busy",  32'(busy), 0);
        check("t5_rst_count", 32'(count), 0);
        check("t5_rst_err",   32'(err), 0);
        check("t5_rst_full",  32'(full), 0);
        wb_ready = 1'b0;
        step();
        reset = 1'b0;

        // Issue and fill in the same cycle on an empty buffer
        do_reset();
        issue_valid = 1'b1; issue_dest = 4'd5; fpu_done = 1'b1; fpu_result = 16'h1234;
        step();
        issue_valid = 1'b0; fpu_done = 1'b0;
        check("t6_valid", 32'(wb_valid), 1);
        check("t6_dest",  32'(wb_dest), 5);
        check("t6_value", 32'(wb_value), 'h1234);
        check("t6_err",   32'(err), 0);
        check("t6_count", 32'(count), 1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("t6_count_after", 32'(count), 0);

        // Writeback latency from fpu_done
        do_reset();
        issue_valid = 1'b1; issue_dest = 4'd4;
        step();
        issue_valid = 1'b0; fpu_done = 1'b1; fpu_result = 16'h4000; wb_ready = 1'b1;
`ifdef FWB_BYPASS_EN
        check("t7_byp_valid", 32'(wb_valid), 1);
        check("t7_byp_value", 32'(wb_value), 'h4000);
        check("t7_byp_dest",  32'(wb_dest), 4);
        step();
        fpu_done = 1'b0;
        check("t7_byp_count", 32'(count), 0);
        check("t7_byp_after", 32'(wb_valid), 0);
        check("t7_byp_busy",  32'(busy), 0);
`else
        check("t7_same_cycle_valid", 32'(wb_valid), 0);
        step();
        fpu_done = 1'b0;
        check("t7_next_valid", 32'(wb_valid), 1);
        check("t7_next_value", 32'(wb_value), 'h4000);
        step();
        check("t7_count", 32'(count), 0);
`endif
        wb_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
